// File: rtl/vector_assembler_pkg.sv
// Shared widths, bank/FSM encodings and the lane popcount helper for the vector assembler.
package vector_assembler_pkg;

  localparam int DATA_W  = 16;
  localparam int LANES   = 4;
  localparam int VEC_LEN = 64;
  localparam int BEATS   = VEC_LEN / LANES;
  localparam int CNT_W   = $clog2(VEC_LEN) + 1;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {
    BANK_FREE = 1'b0,
    BANK_FULL = 1'b1
  } bank_state_e;

  typedef enum logic {
    ST_PRESENT = 1'b0,
    ST_HOLD    = 1'b1
  } out_state_e;

  // Number of valid lanes in a beat's keep mask.
  function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] mask);
    logic [CNT_W-1:0] sum;
    sum = '0;
    for (int k = 0; k < LANES; k++) begin
      sum = sum + CNT_W'(mask[k]);
    end
    return sum;
  endfunction

endpackage

// File: rtl/vector_assembler_if.sv
// Beat input stream and vector output stream of the vector assembler.
interface vector_assembler_if;
  import vector_assembler_pkg::*;

  logic [LANES*DATA_W-1:0] data_in;
  logic [LANES-1:0]        keep_in;
  logic                    last_in;
  logic                    valid_in;
  logic                    ready_in;

  logic [DATA_W-1:0]       data_out [0:VEC_LEN-1];
  logic [CNT_W-1:0]        elem_count;
  logic                    valid_out;
  logic                    ready_out;

  // Producer of beats and consumer of vectors.
  modport master (
    output data_in, keep_in, last_in, valid_in, ready_out,
    input  ready_in, data_out, elem_count, valid_out
  );

  // The assembler itself.
  modport slave (
    input  data_in, keep_in, last_in, valid_in, ready_out,
    output ready_in, data_out, elem_count, valid_out
  );

endinterface

// File: rtl/vector_assembler_vec_bank.sv
// vec_bank: one ping-pong bank holding a full vector, its FULL flag and latched element count.
module vector_assembler_vec_bank
  import vector_assembler_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_wr_en,
  input  logic [BEAT_W-1:0]       i_beat_idx,
  input  logic [LANES*DATA_W-1:0] i_data,
  input  logic [LANES-1:0]        i_keep,
  input  logic                    i_close,
  input  logic [CNT_W-1:0]        i_close_cnt,
  input  logic                    i_release,
  output logic                    o_full,
  output logic [CNT_W-1:0]        o_count,
  output logic [DATA_W-1:0]       o_data [0:VEC_LEN-1]
);

  bank_state_e      r_state;
  logic [CNT_W-1:0] r_count;

  genvar gi;
  generate
    for (gi = 0; gi < VEC_LEN; gi++) begin : g_elem
      localparam int                LANE = gi % LANES;
      localparam logic [BEAT_W-1:0] BEAT = BEAT_W'(gi / LANES);

      logic [DATA_W-1:0] r_elem;

      // Element storage: written by its own beat/lane, zeroed when the bank is released.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_elem <= '0;
        end else if (i_release) begin
          r_elem <= '0;
        end else if (i_wr_en && (i_beat_idx == BEAT)) begin
          r_elem <= i_keep[LANE] ? i_data[LANE*DATA_W +: DATA_W] : '0;
        end
      end

      assign o_data[gi] = r_elem;
    end
  endgenerate

  // Bank state and count: FULL with latched count on frame close, FREE and zero on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BANK_FREE;
      r_count <= '0;
    end else if (i_release) begin
      r_state <= BANK_FREE;
      r_count <= '0;
    end else if (i_close) begin
      r_state <= BANK_FULL;
      r_count <= i_close_cnt;
    end
  end

  assign o_full  = (r_state == BANK_FULL);
  assign o_count = r_count;

endmodule

// File: rtl/vector_assembler.sv
// Packs LANES-wide beats into VEC_LEN-element vectors through two ping-pong banks.
module vector_assembler
  import vector_assembler_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  vector_assembler_if.slave  bus
);

  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0]  r_run_cnt;
  out_state_e        r_state;
  out_state_e        w_state_next;

  logic              w_ready_in;
  logic              w_accept;
  logic              w_close;
  logic [CNT_W-1:0]  w_cnt_sum;
  logic              w_valid_out;
  logic              w_release;

  logic [1:0]        w_full;
  logic [1:0]        w_bank_wr;
  logic [1:0]        w_bank_close;
  logic [1:0]        w_bank_release;
  logic [CNT_W-1:0]  w_count0;
  logic [CNT_W-1:0]  w_count1;
  logic [DATA_W-1:0] w_data0 [0:VEC_LEN-1];
  logic [DATA_W-1:0] w_data1 [0:VEC_LEN-1];

  assign w_ready_in = ~w_full[r_wr_bank];
  assign w_accept   = bus.valid_in && w_ready_in;
  // A frame closes on last_in or when the bank has received its final beat.
  assign w_close    = w_accept && (bus.last_in || (r_beat_cnt == BEAT_W'(BEATS - 1)));
  assign w_cnt_sum  = r_run_cnt + popcount(bus.keep_in);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sel
      assign w_bank_wr[gi]      = w_accept  && (r_wr_bank == 1'(gi));
      assign w_bank_close[gi]   = w_close   && (r_wr_bank == 1'(gi));
      assign w_bank_release[gi] = w_release && (r_rd_bank == 1'(gi));
    end
  endgenerate

  vector_assembler_vec_bank u_vec_bank0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_en     (w_bank_wr[0]),
    .i_beat_idx  (r_beat_cnt),
    .i_data      (bus.data_in),
    .i_keep      (bus.keep_in),
    .i_close     (w_bank_close[0]),
    .i_close_cnt (w_cnt_sum),
    .i_release   (w_bank_release[0]),
    .o_full      (w_full[0]),
    .o_count     (w_count0),
    .o_data      (w_data0)
  );

  vector_assembler_vec_bank u_vec_bank1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_en     (w_bank_wr[1]),
    .i_beat_idx  (r_beat_cnt),
    .i_data      (bus.data_in),
    .i_keep      (bus.keep_in),
    .i_close     (w_bank_close[1]),
    .i_close_cnt (w_cnt_sum),
    .i_release   (w_bank_release[1]),
    .o_full      (w_full[1]),
    .o_count     (w_count1),
    .o_data      (w_data1)
  );

  // Write-side frame tracking and read pointer advance on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_beat_cnt <= '0;
      r_run_cnt  <= '0;
    end else begin
      if (w_accept) begin
        if (w_close) begin
          r_beat_cnt <= '0;
          r_run_cnt  <= '0;
          r_wr_bank  <= ~r_wr_bank;
        end else begin
          r_beat_cnt <= r_beat_cnt + 1'b1;
          r_run_cnt  <= w_cnt_sum;
        end
      end
      if (w_release) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  // Output FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_PRESENT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Output FSM next state: one HOLD cycle after every accepted vector.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_PRESENT: if (w_valid_out && bus.ready_out) w_state_next = ST_HOLD;
      ST_HOLD:    w_state_next = ST_PRESENT;
      default:    w_state_next = ST_PRESENT;
    endcase
  end

  // Output FSM outputs: present a FULL bank, release it at the end of HOLD.
  always_comb begin
    w_valid_out = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_PRESENT: w_valid_out = w_full[r_rd_bank];
      ST_HOLD:    w_release   = 1'b1;
      default:    w_valid_out = 1'b0;
    endcase
  end

  // Output mux: data and count always track the read bank, so they stay put during HOLD.
  generate
    for (gi = 0; gi < VEC_LEN; gi++) begin : g_out
      assign bus.data_out[gi] = r_rd_bank ? w_data1[gi] : w_data0[gi];
    end
  endgenerate

  assign bus.elem_count = r_rd_bank ? w_count1 : w_count0;
  assign bus.valid_out  = w_valid_out;
  assign bus.ready_in   = w_ready_in;

endmodule

// File: tb/tb_vector_assembler.sv
// Directed bench for vector_assembler with a frame scoreboard checked at each output handshake.
module tb_vector_assembler;

  logic clk;
  logic rst_n;

  vector_assembler_if vif ();

  vector_assembler u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard of closed frames, filled as beats are accepted.
  logic [1023:0] exp_data_q[$];
  logic [6:0]    exp_cnt_q[$];

  // Model of the frame currently being assembled.
  logic [1023:0] m_data;
  int            m_cnt;
  int            m_beat;

  logic [1023:0] mon_d;
  logic [6:0]    mon_c;
  logic [1023:0] saved_d;
  logic [6:0]    saved_c;

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1023:0] flat();
    logic [1023:0] v;
    for (int i = 0; i < 64; i++) v[i*16 +: 16] = vif.data_out[i];
    return v;
  endfunction

  // Output monitor: each handshake consumes the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && vif.valid_out === 1'b1 && vif.ready_out === 1'b1) begin
      chk("frame_expected", exp_cnt_q.size() != 0, 1'b1);
      if (exp_cnt_q.size() != 0) begin
        mon_d = exp_data_q.pop_front();
        mon_c = exp_cnt_q.pop_front();
        chk("sb_count", vif.elem_count, mon_c);
        chk("sb_data", flat(), mon_d);
        $display("frame out: count=%0d elem0=0x%0h", vif.elem_count, vif.data_out[0]);
      end
    end
  end

  task automatic model_clear();
    m_data = '0;
    m_cnt  = 0;
    m_beat = 0;
  endtask

  // Drive one beat, wait (bounded) for acceptance, then update the model.
  task automatic send_beat(input logic [63:0] d, input logic [3:0] k, input logic l);
    bit acc;
    acc = 0;
    vif.data_in  = d;
    vif.keep_in  = k;
    vif.last_in  = l;
    vif.valid_in = 1'b1;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      if (vif.ready_in === 1'b1) acc = 1;
      @(posedge clk);
      #1;
    end
    chk("beat_accepted", acc, 1'b1);
    if (acc) begin
      for (int j = 0; j < 4; j++)
        m_data[(m_beat*4 + j)*16 +: 16] = k[j] ? d[j*16 +: 16] : 16'h0;
      m_cnt = m_cnt + $countones(k);
      if (l || m_beat == 15) begin
        exp_data_q.push_back(m_data);
        exp_cnt_q.push_back(7'(m_cnt));
        model_clear();
      end else begin
        m_beat++;
      end
    end
  endtask

  // Beats carry base+element-index values; the final beat uses last_keep/with_last.
  task automatic send_run(input int n_beats, input int base, input logic [3:0] last_keep, input bit with_last);
    logic [63:0] d;
    for (int b = 0; b < n_beats; b++) begin
      for (int j = 0; j < 4; j++) d[j*16 +: 16] = 16'(base + b*4 + j);
      if (b == n_beats - 1) send_beat(d, last_keep, with_last);
      else send_beat(d, 4'hF, 1'b0);
    end
    vif.valid_in = 1'b0;
    vif.last_in  = 1'b0;
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 0;
    for (int t = 0; t < 200 && !seen; t++) begin
      if (vif.valid_out === 1'b1) seen = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("valid_out_seen", seen, 1'b1);
  endtask

  task automatic pulse_ready();
    vif.ready_out = 1'b1;
    @(posedge clk);
    #1;
    vif.ready_out = 1'b0;
  endtask

  // Accept one vector and let the HOLD/release cycle pass.
  task automatic consume();
    wait_valid();
    pulse_ready();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready_in"}, vif.ready_in, 1'b1);
    chk({tag, "_valid_out"}, vif.valid_out, 1'b0);
    chk({tag, "_elem_count"}, vif.elem_count, 7'd0);
    chk({tag, "_data_zero"}, flat(), 1024'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    vif.data_in   = '0;
    vif.keep_in   = '0;
    vif.last_in   = 1'b0;
    vif.valid_in  = 1'b0;
    vif.ready_out = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full frame: element value = index, valid_out the cycle after the closing beat.
    send_run(16, 0, 4'hF, 1'b1);
    chk("full_valid_next", vif.valid_out, 1'b1);
    chk("full_count", vif.elem_count, 7'd64);
    chk("full_elem63", vif.data_out[63], 16'd63);
    consume();

    // Short frame, then two more short frames reusing both banks (no stale data).
    send_run(5, int'($urandom_range(1, 16'h7FFF)), 4'b0011, 1'b1);
    wait_valid();
    chk("short_count", vif.elem_count, 7'd18);
    chk("short_elem18_zero", vif.data_out[18], 16'd0);
    consume();
    send_run(2, 16'h0100, 4'b0001, 1'b1);
    consume();
    send_run(1, 16'h0200, 4'b0111, 1'b1);
    consume();

    // Backpressure: two frames fill both banks, then a single-cycle accept.
    send_run(4, 16'h1000, 4'hF, 1'b1);
    send_run(4, 16'h2000, 4'hF, 1'b1);
    chk("bp_ready_in_low", vif.ready_in, 1'b0);
    @(posedge clk);
    #1;
    chk("bp_ready_in_still_low", vif.ready_in, 1'b0);
    saved_d = flat();
    saved_c = vif.elem_count;
    pulse_ready();
    chk("hold_valid_low", vif.valid_out, 1'b0);
    chk("hold_count_same", vif.elem_count, saved_c);
    chk("hold_data_same", flat(), saved_d);
    chk("hold_ready_in_low", vif.ready_in, 1'b0);
    @(posedge clk);
    #1;
    chk("release_ready_in_high", vif.ready_in, 1'b1);
    chk("release_next_valid", vif.valid_out, 1'b1);
    send_run(3, 16'h3000, 4'hF, 1'b1);
    consume();
    consume();

    // Auto-close: 16 beats fill frame A, beats 17-20 become frame B.
    send_run(20, 16'h4000, 4'hF, 1'b1);
    chk("auto_a_count", vif.elem_count, 7'd64);
    consume();
    wait_valid();
    chk("auto_b_count", vif.elem_count, 7'd16);
    chk("auto_b_elem0", vif.data_out[0], 16'h4040);
    consume();

    // Empty frame: a single last beat with no lanes kept.
    send_run(1, 16'hBEE0, 4'h0, 1'b1);
    chk("empty_valid", vif.valid_out, 1'b1);
    chk("empty_count", vif.elem_count, 7'd0);
    chk("empty_data", flat(), 1024'd0);
    consume();

    // Reset in the middle of a 7-beat partial frame.
    send_run(7, 16'h5000, 4'hF, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_run(2, 16'h6000, 4'hF, 1'b1);
    chk("post_reset_count", vif.elem_count, 7'd8);
    chk("post_reset_elem0", vif.data_out[0], 16'h6000);
    consume();

    chk("scoreboard_drained", exp_cnt_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
